mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 161 ++++++++++++++++
 tb/tb_mdu_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Sequential unsigned multiply/divide unit: shift-add MUL/MULHU and restoring DIVU/REMU,
// 32 iterations per operation, valid/ready handshake on both request and result sides.
module mdu_seq (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [1:0]  i_op,
   input  logic [31:0] i_op_a,
   input  logic [31:0] i_op_b,
   input  logic        i_flush,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_result,
   output logic        o_busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   typedef enum logic [1:0] {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU} op_t;

   state_t      state;
   op_t         op_q;
   logic [4:0]  cnt;
   logic [63:0] acc;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [31:0] divisor;
   logic [31:0] rem;
   logic [31:0] quo;

   logic [32:0] sum;
   logic [63:0] acc_nxt;
   logic [31:0] mplier_nxt;
   logic [32:0] rem_sh;
   logic [32:0] trial;
   logic [31:0] rem_nxt;
   logic [31:0] quo_nxt;
   logic [31:0] calc_result;
   logic        is_div_q;

   assign is_div_q = (op_q == OP_DIVU) || (op_q == OP_REMU);

   // One iteration of each datapath; the FSM picks which one to commit.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      sum         = {1'b0, acc[63:32]};
      if (mplier[0])
         sum = {1'b0, acc[63:32]} + {1'b0, mcand};
      acc_nxt     = {sum, acc[31:1]};
      mplier_nxt  = {1'b0, mplier[31:1]};

      // The bit shifted out of rem must take part in the compare, hence 33 bits.
      rem_sh      = {rem, quo[31]};
      trial       = rem_sh - {1'b0, divisor};
      rem_nxt     = rem_sh[31:0];
      quo_nxt     = {quo[30:0], 1'b0};
      if (!trial[32]) begin
         rem_nxt = trial[31:0];
         quo_nxt = {quo[30:0], 1'b1};
      end

      calc_result = '0;
      case (op_q)
         OP_MUL:   calc_result = acc_nxt[31:0];
         OP_MULHU: calc_result = acc_nxt[63:32];
         OP_DIVU:  calc_result = quo_nxt;
         OP_REMU:  calc_result = rem_nxt;
         default:  calc_result = '0;
      endcase
   end

   // NOTE: all state here is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         op_q     <= OP_MUL;
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         divisor  <= '0;
         rem      <= '0;
         quo      <= '0;
         o_ready  <= 1'b1;
         o_valid  <= 1'b0;
         o_busy   <= 1'b0;
         o_result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid && !i_flush) begin
                  op_q    <= op_t'(i_op);
                  mcand   <= i_op_a;
                  divisor <= i_op_b;
                  cnt     <= '0;
                  o_ready <= 1'b0;
                  o_busy  <= 1'b1;
                  if (i_op[1]) begin
                     rem <= '0;
                     quo <= i_op_a;
                     if (i_op_b == 32'd0) begin
                        // Divide by zero short-circuits straight to the result.
                        state    <= DONE;
                        o_valid  <= 1'b1;
                        o_result <= i_op[0] ? i_op_a : 32'hFFFF_FFFF;
                     end else begin
                        state <= CALC;
                     end
                  end else begin
                     acc    <= '0;
                     mplier <= i_op_b;
                     state  <= CALC;
                  end
               end
            end

            CALC: begin
               if (i_flush) begin
                  state   <= IDLE;
                  o_ready <= 1'b1;
                  o_busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 5'd1;
                  if (is_div_q) begin
                     rem <= rem_nxt;
                     quo <= quo_nxt;
                  end else begin
                     acc    <= acc_nxt;
                     mplier <= mplier_nxt;
                  end
                  if (cnt == 5'd31) begin
                     state    <= DONE;
                     o_valid  <= 1'b1;
                     o_result <= calc_result;
                  end
               end
            end

            DONE: begin
               if (i_flush || i_ready) begin
                  state    <= IDLE;
                  o_valid  <= 1'b0;
                  o_result <= '0;
                  o_ready  <= 1'b1;
                  o_busy   <= 1'b0;
               end
            end

            default: begin
               state    <= IDLE;
               o_valid  <= 1'b0;
               o_result <= '0;
               o_ready  <= 1'b1;
               o_busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: arithmetic vectors, latency, divide by zero,
// backpressure, flush and asynchronous reset behaviour.
module tb_mdu_seq;

   logic        i_clk;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [1:0]  i_op;
   logic [31:0] i_op_a;
   logic [31:0] i_op_b;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_result;
   logic        o_busy;

   int errors = 0;
   int checks = 0;

   localparam logic [1:0] MUL = 2'd0, MULHU = 2'd1, DIVU = 2'd2, REMU = 2'd3;
   localparam int         TIMEOUT = 100;

   mdu_seq dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_op     (i_op),
      .i_op_a   (i_op_a),
      .i_op_b   (i_op_b),
      .i_flush  (i_flush),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_result (o_result),
      .o_busy   (o_busy)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   // Presents one request, returns just after the accept edge with operands scrambled.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge i_clk);
      i_valid = 1'b1;
      i_op    = op;
      i_op_a  = a;
      i_op_b  = b;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_op    = 2'($urandom);
      i_op_a  = $urandom;
      i_op_b  = $urandom;
   endtask

   // Edges counted from the accept edge (inclusive) until o_valid is seen high.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!o_valid && lat < TIMEOUT) begin
         @(posedge i_clk);
         #1;
         lat++;
      end
   endtask

   // Full transaction with i_ready held high; reports result, latency and o_ready after handoff.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic rdy_after);
      i_ready = 1'b1;
      start_op(op, a, b);
      wait_valid(lat);
      res = o_result;
      @(posedge i_clk);
      #1;
      rdy_after = o_ready;
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [34:0] got;
      i_rst = 1'b1;
      #3;
      got = {o_ready, o_valid, o_busy, o_result};
      checks++;
      if (got !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_outputs: got ready/valid/busy/result=%h want %h", got,
                  {1'b1, 1'b0, 1'b0, 32'h0});
      end
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_mul_basic();
      logic [31:0] res;
      int          lat;
      logic        rdy;
      i_ready = 1'b1;
      start_op(MUL, 32'd7, 32'd6);
      checks++;
      if ({o_ready, o_busy, o_valid, o_result} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL mul_calc_flags: got ready/busy/valid/result=%b%b%b/%h want 010/00000000",
                  o_ready, o_busy, o_valid, o_result);
      end
      wait_valid(lat);
      res = o_result;
      @(posedge i_clk);
      #1;
      rdy = o_ready;
      checks++;
      if (lat !== 33) begin
         errors++;
         $display("FAIL mul_latency: got %0d want 33", lat);
      end
      checks++;
      if (res !== 32'h0000_002A) begin
         errors++;
         $display("FAIL mul_7x6: got %h want 0000002a", res);
      end
      checks++;
      if ({rdy, o_valid, o_busy, o_result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL mul_handoff: got ready/valid/busy=%b%b%b result=%h want 100 / 0",
                  rdy, o_valid, o_busy, o_result);
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic test_arith();
      vec_t        v[10];
      logic [31:0] res;
      int          lat;
      logic        rdy;
      v[0] = '{MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      v[1] = '{MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
      v[2] = '{DIVU,  32'd100,       32'd7,         32'h0000_000E, 33};
      v[3] = '{REMU,  32'd100,       32'd7,         32'h0000_0002, 33};
      v[4] = '{DIVU,  32'h8000_0000, 32'd1,         32'h8000_0000, 33};
      v[5] = '{DIVU,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 33};
      v[6] = '{REMU,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      v[7] = '{MULHU, 32'h8000_0000, 32'd4,         32'h0000_0002, 33};
      v[8] = '{DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      v[9] = '{REMU,  32'd5,         32'd0,         32'h0000_0005, 1};
      for (int i = 0; i < 10; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, res, lat, rdy);
         checks++;
         if (res !== v[i].exp) begin
            errors++;
            $display("FAIL arith[%0d] op=%0d a=%h b=%h: got %h want %h",
                     i, v[i].op, v[i].a, v[i].b, res, v[i].exp);
         end
         checks++;
         if (lat !== v[i].lat || rdy !== 1'b1) begin
            errors++;
            $display("FAIL arith_timing[%0d]: got lat=%0d ready=%b want lat=%0d ready=1",
                     i, lat, rdy, v[i].lat);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      int bad = 0;
      i_ready = 1'b0;
      start_op(MUL, 32'h1234_5678, 32'h10);
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge i_clk);
         #1;
         if (o_valid !== 1'b1 || o_result !== 32'h2345_6780) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL backpressure_hold: got %0d unstable cycles want 0 (valid=%b result=%h)",
                  bad, o_valid, o_result);
      end
      @(negedge i_clk);
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      checks++;
      if ({o_valid, o_ready} !== 2'b01) begin
         errors++;
         $display("FAIL backpressure_release: got valid/ready=%b%b want 01", o_valid, o_ready);
      end
   endtask

   // Watches a window of cycles for any o_valid pulse.
   task automatic watch_no_valid(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge i_clk);
         #1;
         if (o_valid) seen++;
      end
   endtask

   task automatic test_flush();
      logic [31:0] res;
      int          lat;
      int          seen;
      logic        rdy;
      i_ready = 1'b1;
      start_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (14) @(posedge i_clk);
      @(negedge i_clk);
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      checks++;
      if ({o_ready, o_busy, o_valid} !== 3'b100) begin
         errors++;
         $display("FAIL flush_calc: got ready/busy/valid=%b%b%b want 100", o_ready, o_busy, o_valid);
      end
      watch_no_valid(40, seen);
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL flush_no_result: got %0d valid cycles want 0", seen);
      end
      run_op(MUL, 32'd3, 32'd4, res, lat, rdy);
      checks++;
      if (res !== 32'd12 || lat !== 33) begin
         errors++;
         $display("FAIL flush_then_mul: got result=%h lat=%0d want 0000000c lat=33", res, lat);
      end
   endtask

   task automatic test_reset_mid_calc();
      logic [31:0] res;
      int          lat;
      int          seen;
      logic        rdy;
      i_ready = 1'b1;
      start_op(DIVU, 32'd1000, 32'd3);
      repeat (19) @(posedge i_clk);
      @(negedge i_clk);
      #2;
      i_rst = 1'b1;
      #1;
      checks++;
      if ({o_ready, o_busy, o_valid, o_result} !== {3'b100, 32'h0}) begin
         errors++;
         $display("FAIL reset_mid_calc: got ready/busy/valid=%b%b%b result=%h want 100 / 0",
                  o_ready, o_busy, o_valid, o_result);
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      watch_no_valid(40, seen);
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_no_result: got %0d valid cycles want 0", seen);
      end
      run_op(MUL, 32'd3, 32'd4, res, lat, rdy);
      checks++;
      if (res !== 32'd12 || lat !== 33) begin
         errors++;
         $display("FAIL reset_then_mul: got result=%h lat=%0d want 0000000c lat=33", res, lat);
      end
   endtask

   task automatic test_flush_idle_and_done();
      int lat;
      @(negedge i_clk);
      i_valid = 1'b1;
      i_flush = 1'b1;
      i_op    = MUL;
      i_op_a  = 32'd9;
      i_op_b  = 32'd9;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_flush = 1'b0;
      checks++;
      if ({o_ready, o_busy} !== 2'b10) begin
         errors++;
         $display("FAIL flush_beats_valid: got ready/busy=%b%b want 10", o_ready, o_busy);
      end
      // Divide by zero parks the block in DONE; a flush there must drop the result.
      i_ready = 1'b0;
      start_op(REMU, 32'd77, 32'd0);
      wait_valid(lat);
      @(negedge i_clk);
      i_flush = 1'b1;
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      checks++;
      if ({o_valid, o_ready, o_busy, o_result} !== {3'b010, 32'h0} || lat !== 1) begin
         errors++;
         $display("FAIL flush_in_done: got valid/ready/busy=%b%b%b result=%h lat=%0d want 010 / 0 / 1",
                  o_valid, o_ready, o_busy, o_result, lat);
      end
   endtask

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_op    = MUL;
      i_op_a  = '0;
      i_op_b  = '0;
      i_flush = 1'b0;
      i_ready = 1'b1;
      test_reset();
      test_mul_basic();
      test_arith();
      test_backpressure();
      test_flush();
      test_reset_mid_calc();
      do_reset();
      test_flush_idle_and_done();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
